// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the execute stage.
// Contents: opcode encodings, bit positions inside the {Z,V,N} flag register,
// signed 16-bit saturation limits, Shifter mode codes, and a saturating
// signed 4-bit add helper used by PADDSB.
package cpu_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RSVD   = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  // Any opcode with bit 3 set is ADDR.
  localparam int unsigned OP_ADDR_BIT = 3;

  // Flags register layout is {Z,V,N}.
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 0;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  // Shifter modes match Opcode[1:0] of the shift opcodes.
  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRA = 2'b01;
  localparam logic [1:0] SH_ROR = 2'b10;

  function automatic logic [3:0] satNibbleAdd(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] s;
    s = a + b;
    if ((a[3] == b[3]) && (s[3] != a[3]))
      return a[3] ? 4'h8 : 4'h7;
    return s;
  endfunction

endpackage

// File: rtl/ex_stage_shifter.sv
// Shifter: 16-bit combinational shifter.
// Ports: ShiftIn  - data to shift
//        ShiftVal - shift amount 0..15 (0 passes ShiftIn unchanged)
//        Mode     - 00 logical left, 01 arithmetic right, 10 rotate right,
//                   11 pass-through
//        ShiftOut - shifted data
module Shifter
  import cpu_pkg::*;
(
  input  logic [15:0] ShiftIn,
  input  logic [3:0]  ShiftVal,
  input  logic [1:0]  Mode,
  output logic [15:0] ShiftOut
);

  logic [31:0] rotWide;

  always_comb begin
    // Rotation as a right shift of the doubled word; low half is the result.
    rotWide  = {ShiftIn, ShiftIn} >> ShiftVal;
    ShiftOut = ShiftIn;
    case (Mode)
      SH_SLL:  ShiftOut = ShiftIn << ShiftVal;
      SH_SRA:  ShiftOut = $signed(ShiftIn) >>> ShiftVal;
      SH_ROR:  ShiftOut = rotWide[15:0];
      default: ShiftOut = ShiftIn;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: single-cycle execute stage (combinational ALU + one output
// register bank + one {Z,V,N} flag register).
// Parameter: SAT_EN - 1 saturates ADD/SUB to signed 16-bit, 0 wraps.
// Ports: clk, rst (sync, active-high)
//        InValid, Opcode, SrcA, SrcB, DstReg - operation presented this cycle
//        Stall - hold all outputs/flags; Flush - kill the presented op
//        OutValid, Result, OutDst - registered result; Flags - {Z,V,N}
module ex_stage
  import cpu_pkg::*;
#(
  parameter bit SAT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        InValid,
  input  logic [3:0]  Opcode,
  input  logic [15:0] SrcA,
  input  logic [15:0] SrcB,
  input  logic [3:0]  DstReg,
  input  logic        Stall,
  input  logic        Flush,
  output logic        OutValid,
  output logic [15:0] Result,
  output logic [3:0]  OutDst,
  output logic [2:0]  Flags
);

  logic [15:0] shiftOut;
  logic [15:0] bOperand;
  logic [15:0] sum;
  logic        overflow;
  logic [15:0] aluResult;
  logic        updZ;
  logic        updVN;
  logic [2:0]  nextFlags;

  Shifter uShifter (
    .ShiftIn  (SrcA),
    .ShiftVal (SrcB[3:0]),
    .Mode     (Opcode[1:0]),
    .ShiftOut (shiftOut)
  );

  always_comb begin
    // SUB is A + ~B + 1, so overflow uses the inverted B sign.
    bOperand  = (Opcode == OP_SUB) ? ~SrcB : SrcB;
    sum       = SrcA + bOperand + {15'b0, (Opcode == OP_SUB)};
    overflow  = (SrcA[15] == bOperand[15]) && (sum[15] != SrcA[15]);
    aluResult = '0;
    updZ      = 1'b0;
    updVN     = 1'b0;
    if (Opcode[OP_ADDR_BIT]) begin
      aluResult = (SrcA & 16'hFFFE) + SrcB;
    end else begin
      case (Opcode)
        OP_ADD, OP_SUB: begin
          if (SAT_EN && overflow)
            aluResult = SrcA[15] ? SAT_NEG : SAT_POS;
          else
            aluResult = sum;
          updZ  = 1'b1;
          updVN = 1'b1;
        end
        OP_XOR: begin
          aluResult = SrcA ^ SrcB;
          updZ      = 1'b1;
        end
        OP_SLL, OP_SRA, OP_ROR: begin
          aluResult = shiftOut;
          updZ      = 1'b1;
        end
        OP_PADDSB: begin
          for (int unsigned i = 0; i < 4; i++)
            aluResult[4*i +: 4] = satNibbleAdd(SrcA[4*i +: 4], SrcB[4*i +: 4]);
        end
        default: aluResult = '0;
      endcase
    end

    nextFlags = Flags;
    if (updZ)
      nextFlags[FLAG_Z] = (aluResult == '0);
    if (updVN) begin
      nextFlags[FLAG_V] = overflow;
      nextFlags[FLAG_N] = aluResult[15];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      OutValid <= 1'b0;
      Result   <= '0;
      OutDst   <= '0;
      Flags    <= '0;
    end else if (Flush) begin
      OutValid <= 1'b0;
    end else if (Stall) begin
      OutValid <= OutValid;
    end else if (InValid) begin
      OutValid <= 1'b1;
      Result   <= aluResult;
      OutDst   <= DstReg;
      Flags    <= nextFlags;
    end else begin
      OutValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage (SAT_EN=1).
module tb_ex_stage;

  logic        clk;
  logic        rst;
  logic        InValid;
  logic [3:0]  Opcode;
  logic [15:0] SrcA;
  logic [15:0] SrcB;
  logic [3:0]  DstReg;
  logic        Stall;
  logic        Flush;
  logic        OutValid;
  logic [15:0] Result;
  logic [3:0]  OutDst;
  logic [2:0]  Flags;

  int checks = 0;
  int errors = 0;

  ex_stage #(.SAT_EN(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .InValid  (InValid),
    .Opcode   (Opcode),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .DstReg   (DstReg),
    .Stall    (Stall),
    .Flush    (Flush),
    .OutValid (OutValid),
    .Result   (Result),
    .OutDst   (OutDst),
    .Flags    (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present inputs for one edge, then sample 1 time unit after it.
  task automatic cycle(input logic v, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] d,
                       input logic st, input logic fl);
    InValid = v; Opcode = op; SrcA = a; SrcB = b; DstReg = d; Stall = st; Flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(1'b1, 4'b0000, 16'h1111, 16'h2222, 4'hA, 1'b0, 1'b0);
    cycle(1'b1, 4'b0000, 16'h1111, 16'h2222, 4'hA, 1'b0, 1'b0);
    rst = 1'b0;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", OutValid); end
    checks++; if (Result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h want 0000", Result); end
    checks++; if (OutDst !== 4'h0) begin errors++; $display("FAIL reset_dst got %h want 0", OutDst); end
    checks++; if (Flags !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", Flags); end
  endtask

  task automatic test_add();
    cycle(1'b1, 4'b0000, 16'h7FFF, 16'h0001, 4'h3, 1'b0, 1'b0);
    checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL add_pos_valid got %b want 1", OutValid); end
    checks++; if (Result !== 16'h7FFF) begin errors++; $display("FAIL add_pos_sat got %h want 7fff", Result); end
    checks++; if (OutDst !== 4'h3) begin errors++; $display("FAIL add_pos_dst got %h want 3", OutDst); end
    checks++; if (Flags !== 3'b010) begin errors++; $display("FAIL add_pos_flags got %b want 010", Flags); end
    cycle(1'b1, 4'b0000, 16'h8000, 16'hFFFF, 4'h4, 1'b0, 1'b0);
    checks++; if (Result !== 16'h8000) begin errors++; $display("FAIL add_neg_sat got %h want 8000", Result); end
    checks++; if (Flags !== 3'b011) begin errors++; $display("FAIL add_neg_flags got %b want 011", Flags); end
    cycle(1'b1, 4'b0000, 16'h1234, 16'h0001, 4'h1, 1'b0, 1'b0);
    checks++; if (Result !== 16'h1235) begin errors++; $display("FAIL add_plain got %h want 1235", Result); end
    checks++; if (Flags !== 3'b000) begin errors++; $display("FAIL add_plain_flags got %b want 000", Flags); end
  endtask

  task automatic test_sub_xor();
    cycle(1'b1, 4'b0001, 16'h8000, 16'h0001, 4'h2, 1'b0, 1'b0);
    checks++; if (Result !== 16'h8000) begin errors++; $display("FAIL sub_neg_sat got %h want 8000", Result); end
    checks++; if (Flags !== 3'b011) begin errors++; $display("FAIL sub_neg_flags got %b want 011", Flags); end
    cycle(1'b1, 4'b0010, 16'h00FF, 16'h00F0, 4'h2, 1'b0, 1'b0);
    checks++; if (Result !== 16'h000F) begin errors++; $display("FAIL xor_result got %h want 000f", Result); end
    checks++; if (Flags !== 3'b011) begin errors++; $display("FAIL xor_vn_held got %b want 011", Flags); end
    cycle(1'b1, 4'b0001, 16'h0005, 16'h0005, 4'h2, 1'b0, 1'b0);
    checks++; if (Result !== 16'h0000) begin errors++; $display("FAIL sub_zero got %h want 0000", Result); end
    checks++; if (Flags !== 3'b100) begin errors++; $display("FAIL sub_zero_flags got %b want 100", Flags); end
    cycle(1'b1, 4'b0010, 16'h00FF, 16'h00F0, 4'h2, 1'b0, 1'b0);
    checks++; if (Flags !== 3'b000) begin errors++; $display("FAIL xor_clear_z got %b want 000", Flags); end
  endtask

  task automatic test_shift();
    cycle(1'b1, 4'b0101, 16'hAB00, 16'h0004, 4'h5, 1'b0, 1'b0);
    checks++; if (Result !== 16'hFAB0) begin errors++; $display("FAIL sra got %h want fab0", Result); end
    cycle(1'b1, 4'b0110, 16'hAB00, 16'h0004, 4'h5, 1'b0, 1'b0);
    checks++; if (Result !== 16'h0AB0) begin errors++; $display("FAIL ror got %h want 0ab0", Result); end
    checks++; if (Flags !== 3'b000) begin errors++; $display("FAIL ror_flags got %b want 000", Flags); end
    cycle(1'b1, 4'b0100, 16'hAB00, 16'h000F, 4'h5, 1'b0, 1'b0);
    checks++; if (Result !== 16'h0000) begin errors++; $display("FAIL sll15 got %h want 0000", Result); end
    checks++; if (Flags !== 3'b100) begin errors++; $display("FAIL sll15_flags got %b want 100", Flags); end
    cycle(1'b1, 4'b0100, 16'h1234, 16'h0010, 4'h5, 1'b0, 1'b0);
    checks++; if (Result !== 16'h1234) begin errors++; $display("FAIL sll0 got %h want 1234", Result); end
    checks++; if (Flags !== 3'b000) begin errors++; $display("FAIL sll0_flags got %b want 000", Flags); end
    cycle(1'b1, 4'b0101, 16'h8001, 16'h0000, 4'h5, 1'b0, 1'b0);
    checks++; if (Result !== 16'h8001) begin errors++; $display("FAIL sra0 got %h want 8001", Result); end
    cycle(1'b1, 4'b0110, 16'h0001, 16'h0001, 4'h5, 1'b0, 1'b0);
    checks++; if (Result !== 16'h8000) begin errors++; $display("FAIL ror1 got %h want 8000", Result); end
  endtask

  task automatic test_paddsb();
    cycle(1'b1, 4'b0010, 16'h1234, 16'h1234, 4'h6, 1'b0, 1'b0);
    cycle(1'b1, 4'b0111, 16'h7777, 16'h1111, 4'h6, 1'b0, 1'b0);
    checks++; if (Result !== 16'h7777) begin errors++; $display("FAIL paddsb_pos got %h want 7777", Result); end
    checks++; if (Flags !== 3'b100) begin errors++; $display("FAIL paddsb_flags got %b want 100", Flags); end
    cycle(1'b1, 4'b0111, 16'h8888, 16'hFFFF, 4'h6, 1'b0, 1'b0);
    checks++; if (Result !== 16'h8888) begin errors++; $display("FAIL paddsb_neg got %h want 8888", Result); end
    cycle(1'b1, 4'b0111, 16'h1234, 16'h1111, 4'h6, 1'b0, 1'b0);
    checks++; if (Result !== 16'h2345) begin errors++; $display("FAIL paddsb_plain got %h want 2345", Result); end
    cycle(1'b1, 4'b0010, 16'h0001, 16'h0000, 4'h6, 1'b0, 1'b0);
    cycle(1'b1, 4'b0111, 16'h0F0F, 16'h0101, 4'h6, 1'b0, 1'b0);
    checks++; if (Result !== 16'h0000) begin errors++; $display("FAIL paddsb_nocarry got %h want 0000", Result); end
    checks++; if (Flags !== 3'b000) begin errors++; $display("FAIL paddsb_noz got %b want 000", Flags); end
  endtask

  task automatic test_addr();
    cycle(1'b1, 4'b1000, 16'h1235, 16'h0010, 4'h7, 1'b0, 1'b0);
    checks++; if (Result !== 16'h1244) begin errors++; $display("FAIL addr_mask got %h want 1244", Result); end
    cycle(1'b1, 4'b1111, 16'hFFFF, 16'h0003, 4'h7, 1'b0, 1'b0);
    checks++; if (Result !== 16'h0001) begin errors++; $display("FAIL addr_wrap got %h want 0001", Result); end
    cycle(1'b1, 4'b1010, 16'h7FFE, 16'h0002, 4'h7, 1'b0, 1'b0);
    checks++; if (Result !== 16'h8000) begin errors++; $display("FAIL addr_nosat got %h want 8000", Result); end
    cycle(1'b1, 4'b1000, 16'h0001, 16'h0000, 4'h7, 1'b0, 1'b0);
    checks++; if (Result !== 16'h0000) begin errors++; $display("FAIL addr_zero got %h want 0000", Result); end
    checks++; if (Flags !== 3'b000) begin errors++; $display("FAIL addr_flags got %b want 000", Flags); end
    cycle(1'b1, 4'b0011, 16'h0001, 16'h0002, 4'h8, 1'b0, 1'b0);
    checks++; if (Result !== 16'h0000 || OutValid !== 1'b1) begin errors++; $display("FAIL rsvd got %h/%b want 0000/1", Result, OutValid); end
    checks++; if (Flags !== 3'b000) begin errors++; $display("FAIL rsvd_flags got %b want 000", Flags); end
  endtask

  task automatic test_stall_flush();
    cycle(1'b1, 4'b0000, 16'h0010, 16'h0020, 4'h5, 1'b0, 1'b0);
    checks++; if (Result !== 16'h0030) begin errors++; $display("FAIL sf_add got %h want 0030", Result); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'b0001, 16'h0005, 16'h0005, 4'h9, 1'b1, 1'b0);
      checks++;
      if (OutValid !== 1'b1 || Result !== 16'h0030 || OutDst !== 4'h5 || Flags !== 3'b000) begin
        errors++;
        $display("FAIL stall_hold%0d got v=%b r=%h d=%h f=%b want v=1 r=0030 d=5 f=000", i, OutValid, Result, OutDst, Flags);
      end
    end
    cycle(1'b1, 4'b0000, 16'h7FFF, 16'h0001, 4'hC, 1'b1, 1'b1);
    checks++;
    if (OutValid !== 1'b0 || Result !== 16'h0030 || OutDst !== 4'h5 || Flags !== 3'b000) begin
      errors++;
      $display("FAIL flush_stall got v=%b r=%h d=%h f=%b want v=0 r=0030 d=5 f=000", OutValid, Result, OutDst, Flags);
    end
    cycle(1'b0, 4'b0001, 16'h0005, 16'h0005, 4'hD, 1'b0, 1'b0);
    checks++; if (OutValid !== 1'b0 || Result !== 16'h0030 || OutDst !== 4'h5) begin errors++; $display("FAIL idle got v=%b r=%h d=%h want v=0 r=0030 d=5", OutValid, Result, OutDst); end
    cycle(1'b1, 4'b0000, 16'h0001, 16'h0001, 4'hE, 1'b0, 1'b1);
    checks++; if (OutValid !== 1'b0 || Result !== 16'h0030) begin errors++; $display("FAIL flush got v=%b r=%h want v=0 r=0030", OutValid, Result); end
    cycle(1'b1, 4'b0010, 16'h0000, 16'h0000, 4'h2, 1'b0, 1'b0);
    checks++; if (OutValid !== 1'b1 || OutDst !== 4'h2 || Flags !== 3'b100) begin errors++; $display("FAIL after_flush got v=%b d=%h f=%b want v=1 d=2 f=100", OutValid, OutDst, Flags); end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 4'b0001, 16'h8000, 16'h0001, 4'h7, 1'b0, 1'b0);
    cycle(1'b1, 4'b0010, 16'h0000, 16'h0000, 4'h7, 1'b0, 1'b0);
    checks++; if (Flags !== 3'b111 || OutValid !== 1'b1) begin errors++; $display("FAIL pre_rst got f=%b v=%b want f=111 v=1", Flags, OutValid); end
    rst = 1'b1;
    cycle(1'b1, 4'b0000, 16'h0001, 16'h0002, 4'h6, 1'b0, 1'b0);
    rst = 1'b0;
    checks++;
    if (OutValid !== 1'b0 || Result !== 16'h0000 || OutDst !== 4'h0 || Flags !== 3'b000) begin
      errors++;
      $display("FAIL mid_rst got v=%b r=%h d=%h f=%b want v=0 r=0000 d=0 f=000", OutValid, Result, OutDst, Flags);
    end
    cycle(1'b1, 4'b0000, 16'h0001, 16'h0002, 4'h6, 1'b0, 1'b0);
    checks++;
    if (OutValid !== 1'b1 || Result !== 16'h0003 || OutDst !== 4'h6 || Flags !== 3'b000) begin
      errors++;
      $display("FAIL post_rst got v=%b r=%h d=%h f=%b want v=1 r=0003 d=6 f=000", OutValid, Result, OutDst, Flags);
    end
  endtask

  initial begin
    rst = 1'b1; InValid = 1'b0; Opcode = '0; SrcA = '0; SrcB = '0;
    DstReg = '0; Stall = 1'b0; Flush = 1'b0;
    test_reset();
    test_add();
    test_sub_xor();
    test_shift();
    test_paddsb();
    test_addr();
    test_stall_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
